// File: rtl/ps2_map_pkg.sv
// Shared types and PS/2 framing constants for the keyboard-to-button mapper.
package ps2_map_pkg;

    // Per-entry behaviour; the reserved encoding behaves as level.
    typedef enum logic [1:0] {
        MODE_LEVEL  = 2'b00,
        MODE_TOGGLE = 2'b01,
        MODE_PULSE  = 2'b10,
        MODE_RSVD   = 2'b11
    } btn_mode_t;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    // {extended, scancode}; zero means "unmapped".
    typedef logic [8:0] key_code_t;

endpackage

// File: rtl/ps2_button_map_if.sv
// Key-event input, table-write port and decoded outputs of the button mapper.
interface ps2_button_map_if #(
    parameter int unsigned NUM_BTN = 16,
    parameter int unsigned IDX_W   = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
);
    logic [64:0]        ps2_key;
    logic               map_wr;
    logic [IDX_W-1:0]   map_idx;
    logic [8:0]         map_code;
    logic [1:0]         map_mode;
    logic [NUM_BTN-1:0] btn_out;
    logic               key_valid;
    logic [8:0]         key_code;
    logic               key_pressed;

    modport master (
        output ps2_key, map_wr, map_idx, map_code, map_mode,
        input  btn_out, key_valid, key_code, key_pressed
    );

    modport slave (
        input  ps2_key, map_wr, map_idx, map_code, map_mode,
        output btn_out, key_valid, key_code, key_pressed
    );
endinterface

// File: rtl/ps2_btn_cell.sv
// One table entry: stored keycode/mode plus the button state it drives.
module ps2_btn_cell import ps2_map_pkg::*; #(
    parameter int unsigned PULSE_W   = 20,
    parameter int unsigned PULSE_LEN = 900000,
    parameter key_code_t   DEF_CODE  = '0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       evt_i,
    input  key_code_t  code_i,
    input  logic       pressed_i,
    input  logic       wr_i,
    input  key_code_t  wr_code_i,
    input  logic [1:0] wr_mode_i,
    output logic       btn_o
);

    key_code_t          code_q, code_d;
    btn_mode_t          mode_q, mode_d;
    logic               held_q, held_d;
    logic               btn_q, btn_d;
    logic [PULSE_W-1:0] cnt_q, cnt_d;
    logic               match;

    // Code 0 is the unmapped marker and never matches, even against a zero entry.
    assign match = evt_i && (code_i != '0) && (code_i == code_q);

    // Next-state: pulse countdown, then event response, then a table write overrides both.
    always_comb begin
        code_d = code_q;
        mode_d = mode_q;
        held_d = held_q;
        btn_d  = btn_q;
        cnt_d  = cnt_q;

        if (cnt_q != '0) begin
            cnt_d = cnt_q - PULSE_W'(1);
            if (cnt_q == PULSE_W'(1)) begin
                btn_d = 1'b0;
            end
        end

        if (match) begin
            case (mode_q)
                MODE_TOGGLE: begin
                    if (!pressed_i) begin
                        held_d = 1'b0;
                    end else if (!held_q) begin
                        btn_d  = ~btn_q;
                        held_d = 1'b1;
                    end
                end
                MODE_PULSE: begin
                    // Break only re-arms; it never shortens a running pulse.
                    if (!pressed_i) begin
                        held_d = 1'b0;
                    end else if (!held_q && (cnt_q == '0)) begin
                        cnt_d  = PULSE_W'(PULSE_LEN);
                        btn_d  = 1'b1;
                        held_d = 1'b1;
                    end
                end
                default: begin
                    btn_d = pressed_i;
                end
            endcase
        end

        if (wr_i) begin
            code_d = wr_code_i;
            mode_d = btn_mode_t'(wr_mode_i);
            held_d = 1'b0;
            btn_d  = 1'b0;
            cnt_d  = '0;
        end
    end

    // Entry state register with synchronous reset to the default table.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            code_q <= DEF_CODE;
            mode_q <= MODE_LEVEL;
            held_q <= 1'b0;
            btn_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            code_q <= code_d;
            mode_q <= mode_d;
            held_q <= held_d;
            btn_q  <= btn_d;
            cnt_q  <= cnt_d;
        end
    end

    assign btn_o = btn_q;

endmodule

// File: rtl/ps2_button_map.sv
// PS/2 key-event decoder feeding a runtime-writable table of button cells.
module ps2_button_map import ps2_map_pkg::*; #(
    parameter int unsigned            NUM_BTN   = 16,
    parameter int unsigned            IDX_W     = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1,
    parameter int unsigned            PULSE_W   = 20,
    parameter int unsigned            PULSE_LEN = 900000,
    parameter logic [NUM_BTN*9-1:0]   DEF_CODES = '0
) (
    input logic              clk_sys,
    input logic              reset,
    ps2_button_map_if.slave  bus
);

    logic       old_toggle_q;
    logic       key_valid_q, key_valid_d;
    key_code_t  key_code_q, key_code_d;
    logic       key_pressed_q, key_pressed_d;

    logic       evt;
    logic       pressed;
    logic       ext;
    key_code_t  code;

    logic [NUM_BTN-1:0] btn;

    assign evt = bus.ps2_key[64] != old_toggle_q;

    // Decode the key snapshot; multi-byte sequences (PrtScr, Pause) collapse to code 0.
    always_comb begin
        pressed = bus.ps2_key[15:8] != PS2_BREAK;
        ext     = pressed ? (bus.ps2_key[15:8] == PS2_EXT) : (bus.ps2_key[23:16] == PS2_EXT);
        code    = (|bus.ps2_key[63:24]) ? key_code_t'(0) : {ext, bus.ps2_key[7:0]};
    end

    // Decoded-event outputs update only on an event; the strobe follows evt directly.
    always_comb begin
        key_valid_d   = evt;
        key_code_d    = key_code_q;
        key_pressed_d = key_pressed_q;
        if (evt) begin
            key_code_d    = code;
            key_pressed_d = pressed;
        end
    end

    // Toggle tracker follows ps2_key[64] even in reset so leaving reset raises no event.
    always_ff @(posedge clk_sys) begin
        old_toggle_q <= bus.ps2_key[64];
        if (reset) begin
            key_valid_q   <= 1'b0;
            key_code_q    <= '0;
            key_pressed_q <= 1'b0;
        end else begin
            key_valid_q   <= key_valid_d;
            key_code_q    <= key_code_d;
            key_pressed_q <= key_pressed_d;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_cell
        logic wr_en;

        // Out-of-range indices never equal any i, so such writes fall away.
        assign wr_en = bus.map_wr && (bus.map_idx == IDX_W'(i));

        ps2_btn_cell #(
            .PULSE_W   (PULSE_W),
            .PULSE_LEN (PULSE_LEN),
            .DEF_CODE  (DEF_CODES[9*i +: 9])
        ) u_cell (
            .clk_i     (clk_sys),
            .rst_i     (reset),
            .evt_i     (evt),
            .code_i    (code),
            .pressed_i (pressed),
            .wr_i      (wr_en),
            .wr_code_i (bus.map_code),
            .wr_mode_i (bus.map_mode),
            .btn_o     (btn[i])
        );
    end

    assign bus.btn_out     = btn;
    assign bus.key_valid   = key_valid_q;
    assign bus.key_code    = key_code_q;
    assign bus.key_pressed = key_pressed_q;

endmodule

// File: tb/tb_ps2_button_map.sv
// Scoreboard bench: each sent key event queues its expected decode and button image.
module tb_ps2_button_map;

    localparam int unsigned NB   = 16;
    localparam int unsigned PLEN = 10;

    typedef struct {
        logic [8:0]    code;
        logic          pressed;
        logic [NB-1:0] btn;
    } sb_item_t;

    logic     clk;
    logic     reset;
    int       n_cmp;
    int       n_err;
    sb_item_t sb_q[$];
    sb_item_t mon_item;

    ps2_button_map_if #(.NUM_BTN(NB)) bus ();

    ps2_button_map #(
        .NUM_BTN   (NB),
        .PULSE_W   (20),
        .PULSE_LEN (PLEN),
        .DEF_CODES (144'h075)
    ) dut (
        .clk_sys (clk),
        .reset   (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Queue the expectation, flip the toggle bit and let the DUT see one edge.
    task automatic send(input logic [63:0] data, input logic [8:0] code, input logic pressed,
                        input logic [NB-1:0] btn);
        sb_q.push_back('{code: code, pressed: pressed, btn: btn});
        bus.ps2_key = {~bus.ps2_key[64], data};
        step();
    endtask

    task automatic write_entry(input int idx, input logic [8:0] code, input logic [1:0] mode);
        bus.map_wr   = 1'b1;
        bus.map_idx  = 4'(idx);
        bus.map_code = code;
        bus.map_mode = mode;
        step();
        bus.map_wr = 1'b0;
    endtask

    // Output side of the scoreboard: every strobe must match the oldest queued event.
    always @(posedge clk) begin
        #1;
        if (bus.key_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_eq("valid_without_stim", 64'(bus.key_valid), 64'd0);
            end else begin
                mon_item = sb_q.pop_front();
                check_eq("key_code", 64'(bus.key_code), 64'(mon_item.code));
                check_eq("key_pressed", 64'(bus.key_pressed), 64'(mon_item.pressed));
                check_eq("btn_out_evt", 64'(bus.btn_out), 64'(mon_item.btn));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        reset        = 1'b1;
        bus.ps2_key  = '0;
        bus.map_wr   = 1'b0;
        bus.map_idx  = '0;
        bus.map_code = '0;
        bus.map_mode = 2'b00;
        step();
        step();
        reset = 1'b0;
        step();

        check_eq("rst_btn", 64'(bus.btn_out), 64'd0);
        check_eq("rst_valid", 64'(bus.key_valid), 64'd0);
        check_eq("rst_code", 64'(bus.key_code), 64'd0);
        check_eq("rst_pressed", 64'(bus.key_pressed), 64'd0);

        // Default entry 0 = 0x75 in level mode.
        send(64'h75, 9'h075, 1'b1, 16'h0001);
        step();
        check_eq("valid_one_cycle", 64'(bus.key_valid), 64'd0);
        send(64'hF075, 9'h075, 1'b0, 16'h0000);

        // Toggle mode on an extended key; repeats ignored until a break re-arms.
        write_entry(3, 9'h16B, 2'b01);
        send(64'hE06B, 9'h16B, 1'b1, 16'h0008);
        for (int r = 0; r < 3; r++) send(64'hE06B, 9'h16B, 1'b1, 16'h0008);
        send(64'hE0F06B, 9'h16B, 1'b0, 16'h0008);
        send(64'hE06B, 9'h16B, 1'b1, 16'h0000);

        // Pulse mode: exactly PLEN high samples, break and re-make have no effect.
        write_entry(5, 9'h005, 2'b10);
        send(64'h05, 9'h005, 1'b1, 16'h0020);
        for (int k = 2; k <= int'(PLEN); k++) begin
            if (k == 3) send(64'hF005, 9'h005, 1'b0, 16'h0020);
            else if (k == 5) send(64'h05, 9'h005, 1'b1, 16'h0020);
            else step();
            check_eq($sformatf("pulse_hi_%0d", k), 64'(bus.btn_out[5]), 64'd1);
        end
        step();
        check_eq("pulse_lo", 64'(bus.btn_out[5]), 64'd0);

        // Shared code across two level entries; long sequence decodes to 0.
        write_entry(1, 9'h029, 2'b00);
        write_entry(2, 9'h029, 2'b00);
        send(64'h29, 9'h029, 1'b1, 16'h0006);
        send(64'h0100_0029, 9'h000, 1'b1, 16'h0006);
        send(64'hF029, 9'h029, 1'b0, 16'h0000);

        // Out-of-range style check not possible at NB=16; instead same-edge write vs event.
        sb_q.push_back('{code: 9'h075, pressed: 1'b1, btn: 16'h0000});
        bus.map_wr   = 1'b1;
        bus.map_idx  = 4'd0;
        bus.map_code = 9'h072;
        bus.map_mode = 2'b00;
        bus.ps2_key  = {~bus.ps2_key[64], 64'h75};
        step();
        bus.map_wr = 1'b0;
        check_eq("wr_clear_wins", 64'(bus.btn_out[0]), 64'd0);
        send(64'h75, 9'h075, 1'b1, 16'h0000);
        send(64'h72, 9'h072, 1'b1, 16'h0001);
        send(64'hF072, 9'h072, 1'b0, 16'h0000);

        // Reset in the middle of a pulse with the toggle bit forced high.
        send(64'h05, 9'h005, 1'b1, 16'h0020);
        step();
        reset       = 1'b1;
        bus.ps2_key = {1'b1, 64'h05};
        step();
        reset = 1'b0;
        check_eq("midrst_btn", 64'(bus.btn_out), 64'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            check_eq($sformatf("midrst_novalid_%0d", c), 64'(bus.key_valid), 64'd0);
        end
        check_eq("midrst_btn_stays", 64'(bus.btn_out), 64'd0);

        // Table back to defaults: 0x75 maps to entry 0, 0x16B and 0x05 unmapped.
        send(64'h75, 9'h075, 1'b1, 16'h0001);
        send(64'hE06B, 9'h16B, 1'b1, 16'h0001);
        send(64'h05, 9'h005, 1'b1, 16'h0001);
        step();
        step();
        check_eq("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
